// File: rtl/fc_layer_seq.sv
// Sequential fully-connected layer: buffers one activation vector, then computes
// OUT neurons one at a time with a shared LANES-wide MAC fed from an external weight ROM.
module fc_layer_seq #(
  parameter int WIDTH = 8,
  parameter int IN    = 128,
  parameter int OUT   = 10,
  parameter int LANES = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [WIDTH-1:0]                  in_data,
  output logic                              w_en,
  output logic [$clog2(OUT*(IN/LANES))-1:0] w_addr,
  input  logic [LANES*WIDTH-1:0]            w_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [WIDTH*2+$clog2(IN)-1:0]     out_data,
  output logic [$clog2(OUT)-1:0]            out_idx,
  output logic                              busy,
  output logic                              done
);

  localparam int C      = IN / LANES;
  localparam int ADDR_W = $clog2(OUT * C);
  localparam int PROD_W = 2 * WIDTH;
  localparam int ACC_W  = WIDTH * 2 + $clog2(IN);
  localparam int IDX_W  = $clog2(OUT);
  localparam int C_W    = (C > 1) ? $clog2(C) : 1;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, EMIT} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]        act_buf [C][LANES];
  logic [C_W-1:0]          ld_chunk;
  logic [LANE_W-1:0]       ld_lane;
  logic [C_W-1:0]          c;
  logic [IDX_W-1:0]        n;
  logic                    vld_p0;
  logic [C_W-1:0]          c_p0;
  logic signed [ACC_W-1:0] sum_p1;
  logic signed [ACC_W-1:0] acc;
  logic                    done_q;
  logic                    last_beat;
  logic                    last_chunk;
  logic                    last_neuron;
  logic                    hs;

  // Unsigned activation times signed weight; the exact product always fits PROD_W bits.
  function automatic logic signed [PROD_W-1:0] mul_us(input logic [WIDTH-1:0] a,
                                                      input logic signed [WIDTH-1:0] w);
    logic signed [PROD_W-1:0] ax;
    logic signed [PROD_W-1:0] wx;
    ax = $signed(PROD_W'(a));
    wx = PROD_W'(w);
    return ax * wx;
  endfunction

  function automatic logic [ACC_W-1:0] relu(input logic signed [ACC_W-1:0] a);
    return a[ACC_W-1] ? '0 : a;
  endfunction

  assign last_beat   = (ld_chunk == C_W'(C - 1)) && (ld_lane == LANE_W'(LANES - 1));
  assign last_chunk  = (c == C_W'(C - 1));
  assign last_neuron = (n == IDX_W'(OUT - 1));
  assign hs          = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    w_en      = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && last_beat) state_nxt = RUN;
      end
      RUN: begin
        w_en = 1'b1;
        if (last_chunk) state_nxt = DRAIN;
      end
      DRAIN: state_nxt = EMIT;
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = last_neuron ? IDLE : RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ld_chunk <= '0;
      ld_lane  <= '0;
      c        <= '0;
      n        <= '0;
      vld_p0   <= 1'b0;
      c_p0     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= hs && last_neuron;
      vld_p0 <= w_en;
      c_p0   <= c;
      unique case (state)
        IDLE: begin
          ld_chunk <= '0;
          ld_lane  <= '0;
        end
        LOAD: begin
          if (in_valid) begin
            if (ld_lane == LANE_W'(LANES - 1)) begin
              ld_lane  <= '0;
              ld_chunk <= ld_chunk + 1'b1;
            end else begin
              ld_lane <= ld_lane + 1'b1;
            end
          end
        end
        RUN: c <= last_chunk ? '0 : c + 1'b1;
        EMIT: if (out_ready) n <= last_neuron ? '0 : n + 1'b1;
        default: ;
      endcase
    end
  end

  // Activation buffer is plain storage: survives reset and is only rewritten by LOAD.
  always_ff @(posedge clk) begin
    if (state == LOAD && in_valid) act_buf[ld_chunk][ld_lane] <= in_data;
  end

  // Stage p0 -> p1: weights for chunk c_p0 arrive one cycle after the address was issued.
  always_comb begin
    sum_p1 = '0;
    for (int j = 0; j < LANES; j++) begin
      sum_p1 = sum_p1 + ACC_W'(mul_us(act_buf[c_p0][LANE_W'(j)],
                                       $signed(w_data[j*WIDTH +: WIDTH])));
    end
  end

  // Stage p1 -> acc: chunk 0 restarts the neuron, later chunks accumulate.
  always_ff @(posedge clk) begin
    if (!rst_n)      acc <= '0;
    else if (vld_p0) acc <= (c_p0 == '0) ? sum_p1 : acc + sum_p1;
  end

  assign w_addr   = w_en ? ADDR_W'(ADDR_W'(n) * ADDR_W'(C) + ADDR_W'(c)) : '0;
  assign out_data = relu(acc);
  assign out_idx  = n;
  assign busy     = (state != IDLE);
  assign done     = done_q;

endmodule

// File: tb/tb_fc_layer_seq.sv
// Scoreboard bench for fc_layer_seq: directed vectors, behavioural weight ROM,
// expected neuron results queued by the stimulus and checked by an output monitor.
module tb_fc_layer_seq;
  localparam int WIDTH  = 8;
  localparam int IN     = 128;
  localparam int OUT    = 10;
  localparam int LANES  = 8;
  localparam int C      = IN / LANES;
  localparam int ADDR_W = $clog2(OUT * C);
  localparam int ACC_W  = 2 * WIDTH + $clog2(IN);
  localparam int IDX_W  = $clog2(OUT);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [WIDTH-1:0] in_data = '0;
  logic in_ready, w_en, out_valid, busy, done;
  logic [ADDR_W-1:0] w_addr;
  logic [LANES*WIDTH-1:0] w_data = '0;
  logic [ACC_W-1:0] out_data;
  logic [IDX_W-1:0] out_idx;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int amode = 0, aconst = 1, wmode = 0, wconst = 1;
  int last_beat_cyc = 0;
  int exp_idx_q[$];
  int exp_val_q[$];
  logic spacing_chk = 1'b0;

  fc_layer_seq #(.WIDTH(WIDTH), .IN(IN), .OUT(OUT), .LANES(LANES)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [LANES*WIDTH-1:0] rom_word(input int addr);
    logic [LANES*WIDTH-1:0] wd;
    int nn, wv;
    nn = addr / C;
    wd = '0;
    for (int j = 0; j < LANES; j++) begin
      case (wmode)
        0:       wv = wconst;
        1:       wv = j + 1 - nn;
        default: wv = j + 1;
      endcase
      wd[j*WIDTH +: WIDTH] = WIDTH'(wv);
    end
    return wd;
  endfunction

  // Garbage on the bus when not enabled exposes accumulation at the wrong time.
  always @(posedge clk) begin
    if (w_en) w_data <= rom_word(int'(w_addr));
    else      w_data <= {$urandom, $urandom};
  end

  function automatic int act_val(input int i);
    case (amode)
      0:       return aconst;
      1:       return i / LANES + 1;
      default: return i % LANES + 1;
    endcase
  endfunction

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_all(input int val);
    for (int i = 0; i < OUT; i++) begin
      exp_idx_q.push_back(i);
      exp_val_q.push_back(val);
    end
  endtask

  task automatic load_vec(input int am, input int ac);
    amode = am;
    aconst = ac;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < IN; i++) begin
      in_data = WIDTH'(act_val(i));
      tick();
    end
    in_valid = 1'b0;
    last_beat_cyc = cyc;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (!done && k < budget) begin
      tick();
      k++;
    end
    chk("done_seen", done, 1);
    chk("queue_empty", exp_idx_q.size(), 0);
  endtask

  task automatic wait_addr(input int a, input int budget);
    int k;
    k = 0;
    while (!(w_en && w_addr == ADDR_W'(a)) && k < budget) begin
      tick();
      k++;
    end
    chk("addr_reached", (w_en && w_addr == ADDR_W'(a)), 1);
  endtask

  // Output monitor: pops the scoreboard on every handshake and checks the done pulse.
  initial begin
    int last_hs_cyc;
    logic prev_final;
    last_hs_cyc = 0;
    prev_final = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (prev_final || done) begin
          chk("done_pulse", done, prev_final);
          if (done) chk("busy_at_done", busy, 0);
        end
        prev_final = 1'b0;
        if (out_valid && out_ready) begin
          if (exp_idx_q.size() == 0) begin
            chk("unexpected_output", 1, 0);
          end else begin
            chk("out_idx", out_idx, exp_idx_q.pop_front());
            chk("out_data", out_data, exp_val_q.pop_front());
          end
          if (spacing_chk && out_idx != 0) chk("neuron_spacing", cyc - last_hs_cyc, C + 2);
          last_hs_cyc = cyc;
          prev_final = (out_idx == IDX_W'(OUT - 1));
        end
      end else begin
        prev_final = 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t4_exp[OUT];
    t4_exp = '{576, 448, 320, 192, 64, 0, 0, 0, 0, 0};

    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_w_en", w_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_w_addr", w_addr, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_idx", out_idx, 0);
    rst_n = 1'b1;
    tick();

    // All ones: 128 per neuron, latency and spacing
    wmode = 0; wconst = 1;
    push_all(128);
    spacing_chk = 1'b1;
    load_vec(0, 1);
    chk("run_w_en", w_en, 1);
    chk("run_first_addr", w_addr, 0);
    chk("run_busy", busy, 1);
    repeat (C) tick();
    chk("drain_w_en", w_en, 0);
    chk("drain_out_valid", out_valid, 0);
    tick();
    chk("emit_latency_valid", out_valid, 1);
    chk("emit_latency_cycle", cyc - last_beat_cyc, C + 1);
    wait_done(400);
    spacing_chk = 1'b0;

    // Negative accumulator clipped by ReLU
    wconst = -1;
    push_all(0);
    load_vec(0, 255);
    wait_done(400);

    // Largest positive sum fits the accumulator
    wconst = 127;
    push_all(4145280);
    load_vec(0, 255);
    wait_done(400);

    // Neuron-dependent weights (j+1-n): exercises addressing and the ReLU edge
    wmode = 1;
    for (int i = 0; i < OUT; i++) begin
      exp_idx_q.push_back(i);
      exp_val_q.push_back(t4_exp[i]);
    end
    load_vec(0, 1);
    wait_done(400);

    // Chunk-dependent activations
    wmode = 0; wconst = 1;
    push_all(1088);
    load_vec(1, 0);
    wait_done(400);

    // Lane-dependent activations and weights
    wmode = 2;
    push_all(3264);
    load_vec(2, 0);
    wait_done(400);

    // Backpressure at neuron 3
    wmode = 0; wconst = 1;
    push_all(128);
    load_vec(0, 1);
    wait_addr(3 * C, 200);
    out_ready = 1'b0;
    begin
      int k;
      k = 0;
      while (!out_valid && k < 40) begin
        tick();
        k++;
      end
    end
    chk("stall_valid_seen", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      chk("stall_out_valid", out_valid, 1);
      chk("stall_out_data", out_data, 128);
      chk("stall_out_idx", out_idx, 3);
      chk("stall_w_en", w_en, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("resume_w_en", w_en, 1);
    chk("resume_w_addr", w_addr, 4 * C);
    wait_done(400);

    // Reset during neuron 4 RUN, then a fresh vector
    push_all(128);
    load_vec(0, 1);
    wait_addr(4 * C + 5, 200);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_w_en", w_en, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_w_addr", w_addr, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_out_idx", out_idx, 0);
    exp_idx_q.delete();
    exp_val_q.delete();
    tick();
    chk("post_rst_busy", busy, 0);
    push_all(128);
    load_vec(0, 1);
    wait_done(400);

    // in_valid in IDLE and start during RUN are ignored
    in_valid = 1'b1;
    in_data = '0;
    for (int i = 0; i < 4; i++) begin
      chk("idle_in_ready", in_ready, 0);
      chk("idle_busy", busy, 0);
      tick();
    end
    in_valid = 1'b0;
    push_all(128);
    load_vec(0, 1);
    tick();
    tick();
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    wait_done(400);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("after_done_busy", busy, 0);
      chk("after_done_in_ready", in_ready, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
